// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters driving registered
// sync, data-enable, cell coordinates and frame/blink outputs.
module video_timing_gen #(
  parameter int FRAME_WIDTH   = 2200,
  parameter int FRAME_HEIGHT  = 1125,
  parameter int ACTIVE_WIDTH  = 1920,
  parameter int ACTIVE_HEIGHT = 1080,
  parameter int H_PORCH       = 88,
  parameter int H_SYNC        = 44,
  parameter int V_PORCH       = 4,
  parameter int V_SYNC        = 5,
  parameter bit HS_POL        = 1'b1,
  parameter bit VS_POL        = 1'b1,
  parameter int CELL_W_LOG2   = 3,
  parameter int CELL_H_LOG2   = 3,
  parameter int BLINK_BIT     = 5
) (
  input  logic                    i_pclk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  output logic [11:0]             o_px,
  output logic [11:0]             o_py,
  output logic [11-CELL_W_LOG2:0] o_bx,
  output logic [11-CELL_H_LOG2:0] o_by,
  output logic [CELL_W_LOG2-1:0]  o_cx,
  output logic [CELL_H_LOG2-1:0]  o_cy,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic                    o_de,
  output logic                    o_sol,
  output logic                    o_sof,
  output logic                    o_offscreen,
  output logic [7:0]              o_frame,
  output logic                    o_blink
);

  if (ACTIVE_WIDTH + H_PORCH + H_SYNC > FRAME_WIDTH) begin : g_bad_h
    $error("horizontal timing exceeds FRAME_WIDTH");
  end
  if (ACTIVE_HEIGHT + V_PORCH + V_SYNC > FRAME_HEIGHT) begin : g_bad_v
    $error("vertical timing exceeds FRAME_HEIGHT");
  end
  if (FRAME_WIDTH > 4096 || FRAME_HEIGHT > 4096) begin : g_bad_sz
    $error("frame dimensions exceed 12-bit counters");
  end
  if (BLINK_BIT > 7) begin : g_bad_blink
    $error("BLINK_BIT out of frame counter range");
  end

  // 13-bit constants so a 4096-wide frame does not alias to zero
  localparam logic [12:0] XMAX  = 13'(FRAME_WIDTH - 1);
  localparam logic [12:0] YMAX  = 13'(FRAME_HEIGHT - 1);
  localparam logic [12:0] AW    = 13'(ACTIVE_WIDTH);
  localparam logic [12:0] AH    = 13'(ACTIVE_HEIGHT);
  localparam logic [12:0] HS_B  = 13'(ACTIVE_WIDTH + H_PORCH);
  localparam logic [12:0] HS_E  = 13'(ACTIVE_WIDTH + H_PORCH + H_SYNC);
  localparam logic [12:0] VS_B  = 13'(ACTIVE_HEIGHT + V_PORCH);
  localparam logic [12:0] VS_E  = 13'(ACTIVE_HEIGHT + V_PORCH + V_SYNC);

  logic [11:0] x_q, x_d, y_q, y_d;
  logic [7:0]  frame_q, frame_d;
  logic [12:0] xe, ye;
  logic        x_wrap, y_wrap;
  logic        hs_act, vs_act, de_d;

  logic [11:0]             px_q, py_q;
  logic [11-CELL_W_LOG2:0] bx_q;
  logic [11-CELL_H_LOG2:0] by_q;
  logic [CELL_W_LOG2-1:0]  cx_q;
  logic [CELL_H_LOG2-1:0]  cy_q;
  logic hs_q, vs_q, de_q, sol_q, sof_q, off_q;

  always_comb begin
    xe      = {1'b0, x_q};
    ye      = {1'b0, y_q};
    x_wrap  = (xe == XMAX);
    y_wrap  = (ye == YMAX);
    x_d     = x_wrap ? '0 : x_q + 12'd1;
    y_d     = y_q;
    if (x_wrap) y_d = y_wrap ? '0 : y_q + 12'd1;
    frame_d = (x_wrap && y_wrap) ? frame_q + 8'd1 : frame_q;
    hs_act  = (xe >= HS_B) && (xe < HS_E);
    vs_act  = (ye >= VS_B) && (ye < VS_E);
    de_d    = (xe < AW) && (ye < AH);
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      off_q   <= 1'b0;
    end else if (i_en) begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      px_q    <= x_q;
      py_q    <= y_q;
      bx_q    <= x_q[11:CELL_W_LOG2];
      by_q    <= y_q[11:CELL_H_LOG2];
      cx_q    <= x_q[CELL_W_LOG2-1:0];
      cy_q    <= y_q[CELL_H_LOG2-1:0];
      hs_q    <= hs_act ? HS_POL : ~HS_POL;
      vs_q    <= vs_act ? VS_POL : ~VS_POL;
      de_q    <= de_d;
      sol_q   <= (x_q == 12'd0);
      sof_q   <= (x_q == 12'd0) && (y_q == 12'd0);
      off_q   <= (ye >= AH);
    end
  end

  assign o_px        = px_q;
  assign o_py        = py_q;
  assign o_bx        = bx_q;
  assign o_by        = by_q;
  assign o_cx        = cx_q;
  assign o_cy        = cy_q;
  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_sol       = sol_q;
  assign o_sof       = sof_q;
  assign o_offscreen = off_q;
  assign o_frame     = frame_q;
  assign o_blink     = frame_q[BLINK_BIT];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed steps plus random enable,
// checked against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int FW = 10;
  localparam int FH = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rst2_n, en2;

  logic [11:0] px, py;
  logic [10:0] bx, by;
  logic [0:0]  cx, cy;
  logic        hs, vs, de, sol, sof, off, blink;
  logic [7:0]  frame;

  logic [11:0] px2, py2;
  logic [10:0] bx2, by2;
  logic [0:0]  cx2, cy2;
  logic        hs2, vs2, de2, sol2, sof2, off2, blink2;
  logic [7:0]  frame2;

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;
  int n2       = 0;

  video_timing_gen #(
    .FRAME_WIDTH(10), .FRAME_HEIGHT(6),
    .ACTIVE_WIDTH(6), .ACTIVE_HEIGHT(4),
    .H_PORCH(1), .H_SYNC(2), .V_PORCH(1), .V_SYNC(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CELL_W_LOG2(1), .CELL_H_LOG2(1), .BLINK_BIT(1)
  ) dut (
    .i_pclk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_px(px), .o_py(py), .o_bx(bx), .o_by(by),
    .o_cx(cx), .o_cy(cy), .o_hs(hs), .o_vs(vs), .o_de(de),
    .o_sol(sol), .o_sof(sof), .o_offscreen(off),
    .o_frame(frame), .o_blink(blink)
  );

  video_timing_gen #(
    .FRAME_WIDTH(10), .FRAME_HEIGHT(6),
    .ACTIVE_WIDTH(6), .ACTIVE_HEIGHT(4),
    .H_PORCH(1), .H_SYNC(2), .V_PORCH(1), .V_SYNC(1),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .CELL_W_LOG2(1), .CELL_H_LOG2(1), .BLINK_BIT(1)
  ) dut2 (
    .i_pclk(clk), .i_rst_n(rst2_n), .i_en(en2),
    .o_px(px2), .o_py(py2), .o_bx(bx2), .o_by(by2),
    .o_cx(cx2), .o_cy(cy2), .o_hs(hs2), .o_vs(vs2), .o_de(de2),
    .o_sol(sol2), .o_sof(sof2), .o_offscreen(off2),
    .o_frame(frame2), .o_blink(blink2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h n=%0d",
             tag, obs, exp_v, n);
    end
  endtask

  // Outputs after n enabled edges show raster position n-1.
  task automatic check_all();
    int p, x, y, fr;
    logic [7:0] frv;
    if (n == 0) begin
      chk("rst_px", px, 0);   chk("rst_py", py, 0);
      chk("rst_bx", bx, 0);   chk("rst_by", by, 0);
      chk("rst_cx", cx, 0);   chk("rst_cy", cy, 0);
      chk("rst_hs", hs, 0);   chk("rst_vs", vs, 0);
      chk("rst_de", de, 0);   chk("rst_sol", sol, 0);
      chk("rst_sof", sof, 0); chk("rst_off", off, 0);
      chk("rst_frame", frame, 0);
      chk("rst_blink", blink, 0);
    end else begin
      p   = n - 1;
      x   = p % FW;
      y   = (p / FW) % FH;
      fr  = (n / (FW * FH)) % 256;
      frv = 8'(fr);
      chk("px", px, x);
      chk("py", py, y);
      chk("bx", bx, x / 2);
      chk("by", by, y / 2);
      chk("cx", cx, x % 2);
      chk("cy", cy, y % 2);
      chk("hs", hs, (x == 7 || x == 8) ? 1 : 0);
      chk("vs", vs, (y == 5) ? 1 : 0);
      chk("de", de, (x < 6 && y < 4) ? 1 : 0);
      chk("sol", sol, (x == 0) ? 1 : 0);
      chk("sof", sof, (x == 0 && y == 0) ? 1 : 0);
      chk("off", off, (y >= 4) ? 1 : 0);
      chk("frame", frame, fr);
      chk("blink", blink, 32'(frv[1]));
    end
  endtask

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    #1;
    if (e && rst_n) n++;
    if (rst2_n) n2++;
    check_all();
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    rst2_n = 1'b0;
    en2    = 1'b1;
    #3;
    check_all();
    tick(1);
    rst_n = 1'b1;

    tick(1);
    chk("first_sof", sof, 1);
    chk("first_de", de, 1);
    repeat (10) tick(1);
    chk("px_wrap", px, 0);

    while (n < 36) tick(1);
    chk("cell_bx", bx, 2);
    chk("cell_cx", cx, 1);
    chk("cell_by", by, 1);
    chk("cell_cy", cy, 1);

    while (n < 60) tick(1);
    chk("frame_60", frame, 1);

    while ((n - 1) % FW != 4) tick(1);
    repeat (7) tick(0);
    chk("frozen_px", px, 4);
    tick(1);
    chk("resume_px", px, 5);

    repeat (400) tick($urandom_range(0, 3) != 0);
    repeat (300) tick(1);

    while ((n - 1) % FW != 3) tick(1);
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rerun_sof", sof, 1);

    rst2_n = 1'b1;
    n2 = 0;
    while (n2 < 7) tick(0);
    chk("hs2_idle", hs2, 1);
    tick(0);
    chk("hs2_px", px2, 7);
    chk("hs2_active", hs2, 0);
    rst2_n = 1'b0;
    #1;
    chk("hs2_async", hs2, 1);
    chk("hs2_rst_px", px2, 0);
    chk("hs2_rst_de", de2, 0);
    tick(0);
    rst2_n = 1'b1;
    n2 = 0;
    tick(0);
    chk("hs2_re_px", px2, 0);
    chk("hs2_re_sof", sof2, 1);
    chk("hs2_re_hs", hs2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
